// File: rtl/prio_event_pkg.sv
// Shared types and helpers for the registered priority event encoder.
package prio_event_pkg;

  typedef enum logic {
    PRIO_FIXED,
    PRIO_RR
  } prio_mode_e;

  typedef enum logic {
    ST_IDLE,
    ST_PRESENT
  } state_e;

  // A one-bit code is still needed when only two requests exist.
  function automatic int clog2_min1(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prio_event_encoder_pick.sv
// Rotated highest-set-bit search; search starts at start-1 and wraps.
import prio_event_pkg::*;

module prio_pick #(
  parameter int N = 8,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] start,
  input  logic         rr_en,
  output logic [W-1:0] idx,
  output logic         any
);

  int         w_base;
  logic [W-1:0] w_pos;

  // Fixed mode is the rotation with start 0: N-1 first, 0 last.
  always_comb begin
    w_base = rr_en ? int'(start) : 0;
    w_pos  = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = W'((w_base + 2 * N - 1 - k) % N);
      if (cand[w_pos]) begin
        idx = w_pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Sticky pending register, valid/ready code output and round-robin pointer.
import prio_event_pkg::*;

module prio_event_encoder #(
  parameter int N       = 8,
  parameter int W       = clog2_min1(N),
  parameter int RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [W-1:0] code_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] pending_o
);

  localparam prio_mode_e MODE = (RR_MODE != 0) ? PRIO_RR : PRIO_FIXED;

  state_e       r_state;
  state_e       w_state_next;
  logic [N-1:0] r_pending;
  logic [W-1:0] r_code;
  logic [W-1:0] w_code_next;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_next;

  logic         w_accept;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_pend_next;
  logic [N-1:0] w_cand;
  logic [W-1:0] w_pick_idx;
  logic         w_pick_any;

  assign w_accept    = (r_state == ST_PRESENT) && ready_i;
  assign w_clr       = w_accept ? (N'(1) << r_code) : '0;
  assign w_pend_next = (r_pending & ~w_clr) | req;
  assign w_cand      = w_pend_next & mask;
  assign w_ptr_next  = w_accept ? r_code : r_ptr;

  // Same-edge pick must already see the pointer of this accept.
  prio_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .cand (w_cand),
    .start(w_ptr_next),
    .rr_en(MODE == PRIO_RR),
    .idx  (w_pick_idx),
    .any  (w_pick_any)
  );

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_next = ST_PRESENT;
          w_code_next  = w_pick_idx;
        end
      end
      ST_PRESENT: begin
        if (w_accept) begin
          if (w_pick_any) begin
            w_code_next = w_pick_idx;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_code    <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pend_next;
      r_code    <= w_code_next;
      r_ptr     <= w_ptr_next;
    end
  end

  assign code_o    = r_code;
  assign valid_o   = (r_state == ST_PRESENT);
  assign pending_o = r_pending;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench: fixed and round-robin instances share one stimulus stream.
module tb_prio_event_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         ready_i;

  logic [W-1:0] f_code;
  logic         f_valid;
  logic [N-1:0] f_pend;
  logic [W-1:0] r_code;
  logic         r_valid;
  logic [N-1:0] r_pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prio_event_encoder #(.N(N), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .code_o(f_code), .valid_o(f_valid), .ready_i(ready_i),
    .pending_o(f_pend)
  );

  prio_event_encoder #(.N(N), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .code_o(r_code), .valid_o(r_valid), .ready_i(ready_i),
    .pending_o(r_pend)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; mask = 8'hFF; ready_i = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(f_valid), 0);
    chk("rst_code", 32'(f_code), 0);
    chk("rst_pend", 32'(f_pend), 0);
    chk("rst_rr_valid", 32'(r_valid), 0);
    rst = 1'b0;
    tick();

    // 1: burst drains highest-first, one code per cycle
    req = 8'b1001_0011; tick(); req = '0;
    chk("t1_c0", 32'(f_code), 7);
    chk("t1_v0", 32'(f_valid), 1);
    chk("t1_p0", 32'(f_pend), 32'h93);
    tick(); chk("t1_c1", 32'(f_code), 4);
    chk("t1_rr_c1", 32'(r_code), 4);
    tick(); chk("t1_c2", 32'(f_code), 1);
    chk("t1_p2", 32'(f_pend), 32'h03);
    tick(); chk("t1_c3", 32'(f_code), 0);
    tick(); chk("t1_vend", 32'(f_valid), 0);
    chk("t1_pend", 32'(f_pend), 0);
    tick(); chk("t1_idle", 32'(f_valid), 0);

    // 2: backpressure holds code against higher arrival
    ready_i = 1'b0; req = 8'b0000_0100; tick();
    chk("t2_c", 32'(f_code), 2);
    chk("t2_v", 32'(f_valid), 1);
    req = 8'b1000_0000; tick(); req = '0;
    chk("t2_hold", 32'(f_code), 2);
    chk("t2_p", 32'(f_pend), 32'h84);
    ready_i = 1'b1; tick();
    chk("t2_next", 32'(f_code), 7);
    chk("t2_nv", 32'(f_valid), 1);
    chk("t2_np", 32'(f_pend), 32'h80);
    tick(); chk("t2_end", 32'(f_valid), 0);

    // 3: masked bits stay pending but are not presented
    ready_i = 1'b0; mask = 8'b0111_1111; req = 8'b1100_0000; tick();
    req = '0;
    chk("t3_c", 32'(f_code), 6);
    ready_i = 1'b1; tick();
    chk("t3_p", 32'(f_pend), 32'h80);
    chk("t3_v", 32'(f_valid), 0);
    tick();
    chk("t3_keep", 32'(f_pend), 32'h80);
    chk("t3_kv", 32'(f_valid), 0);
    mask = 8'hFF; tick();
    chk("t3_unmask", 32'(f_code), 7);
    chk("t3_uv", 32'(f_valid), 1);
    tick(); chk("t3_end", 32'(f_valid), 0);

    // 4: held requests; RR pointer is 7 here so it starts at 0
    req = 8'b1000_0001; tick();
    chk("t4_f0", 32'(f_code), 7); chk("t4_r0", 32'(r_code), 0);
    tick();
    chk("t4_f1", 32'(f_code), 7); chk("t4_r1", 32'(r_code), 7);
    tick();
    chk("t4_f2", 32'(f_code), 7); chk("t4_r2", 32'(r_code), 0);
    tick();
    chk("t4_f3", 32'(f_code), 7); chk("t4_r3", 32'(r_code), 7);
    chk("t4_fp", 32'(f_pend), 32'h81);
    req = '0; tick();
    chk("t4_f4", 32'(f_code), 0); chk("t4_r4", 32'(r_code), 0);
    tick();
    chk("t4_fv", 32'(f_valid), 0); chk("t4_rv", 32'(r_valid), 0);

    // 5: request on the bit being cleared re-arms it
    ready_i = 1'b0; req = 8'b0000_1000; tick();
    chk("t5_c", 32'(f_code), 3);
    ready_i = 1'b1; tick();
    chk("t5_p", 32'(f_pend), 32'h08);
    chk("t5_re", 32'(f_code), 3);
    chk("t5_rv", 32'(f_valid), 1);
    req = '0; tick();
    chk("t5_end", 32'(f_valid), 0);

    // 6: leave RR pointer at 1, then reset asynchronously
    req = 8'b0000_0010; tick(); req = '0;
    chk("t6_pre", 32'(r_code), 1);
    tick();
    ready_i = 1'b0; req = 8'h0F; tick(); req = '0;
    chk("t6_rc", 32'(r_code), 0);
    chk("t6_fc", 32'(f_code), 3);
    chk("t6_p", 32'(f_pend), 32'h0F);
    #3 rst = 1'b1;
    #1;
    chk("t6_av", 32'(f_valid), 0);
    chk("t6_ac", 32'(f_code), 0);
    chk("t6_ap", 32'(f_pend), 0);
    chk("t6_rav", 32'(r_valid), 0);
    chk("t6_rap", 32'(r_pend), 0);
    tick();
    rst = 1'b0;
    req = 8'b0000_0011; tick(); req = '0;
    chk("t6_rr1", 32'(r_code), 1);
    chk("t6_rv1", 32'(r_valid), 1);
    chk("t6_f1", 32'(f_code), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
